// File: rtl/beep_scheduler.sv
// beep_scheduler: arbitrates front-panel beep requests and sequences the shared
// tone generator. Each request is latched with its beep kind, granted by fixed
// priority (index 0 highest) and played as a short, long or double-short tone.
// Every tone is followed by a silent gap.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   enable     in   advance enable; FSM, counters and outputs freeze when low
//   req        in   per-requester request strobe [NREQ]
//   kind       in   per-requester beep kind, 2 bits each (00 short, 01 long,
//                   10 double-short, 11 short)
//   ack        out  one-cycle grant pulse per requester
//   active_id  out  index of the requester being served
//   busy       out  FSM not idle or any request pending
//   s_enable   out  tone generator enable
//   sonido     out  frequency word (FREQ_WORD while s_enable, else 0)
module beep_scheduler #(
    parameter int unsigned NREQ         = 3,
    parameter int unsigned SHORT_CYCLES = 5000000,
    parameter int unsigned LONG_CYCLES  = 25000000,
    parameter int unsigned GAP_CYCLES   = 2500000,
    parameter int unsigned FREQ_WORD    = 32000,
    parameter int unsigned CNT_W        = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] kind,
    output logic [NREQ-1:0]   ack,
    output logic [1:0]        active_id,
    output logic              busy,
    output logic              s_enable,
    output logic [51:0]       sonido
);

    localparam int unsigned SND_W = 52;
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]  KIND_LONG   = 2'b01;
    localparam logic [1:0]  KIND_DOUBLE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]        pend_q, pend_d;
    logic [NREQ-1:0][1:0]   kind_q, kind_d;
    logic                   dbl_q, dbl_d;
    logic                   second_q, second_d;
    logic [1:0]             id_q, id_d;
    logic [NREQ-1:0]        ack_q, ack_d;
    logic                   ton_q, ton_d;
    logic [SND_W-1:0]       sonido_q, sonido_d;
    logic                   busy_q, busy_d;

    logic [NREQ-1:0]        grant;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic [1:0]             sel_kind;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            kind_q   <= '0;
            dbl_q    <= 1'b0;
            second_q <= 1'b0;
            id_q     <= '0;
            ack_q    <= '0;
            ton_q    <= 1'b0;
            sonido_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            kind_q   <= kind_d;
            dbl_q    <= dbl_d;
            second_q <= second_d;
            id_q     <= id_d;
            ack_q    <= ack_d;
            ton_q    <= ton_d;
            sonido_q <= sonido_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state, grant and pending-latch logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        kind_d   = kind_q;
        dbl_d    = dbl_q;
        second_d = second_q;
        id_d     = id_q;
        ack_d    = '0;
        ton_d    = ton_q;
        sonido_d = sonido_q;
        grant    = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        sel_kind = 2'b00;

        // Lowest pending index wins; scan downward so the last hit is the lowest
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                gnt_idx = IDX_W'(i);
                gnt_any = 1'b1;
            end
        end

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        grant[gnt_idx] = 1'b1;
                        sel_kind       = kind_q[gnt_idx];
                        ack_d          = grant;
                        id_d           = 2'(gnt_idx);
                        cnt_d          = (sel_kind == KIND_LONG) ? CNT_W'(LONG_CYCLES - 1)
                                                                 : CNT_W'(SHORT_CYCLES - 1);
                        dbl_d          = (sel_kind == KIND_DOUBLE);
                        second_d       = 1'b0;
                        ton_d          = 1'b1;
                        sonido_d       = SND_W'(FREQ_WORD);
                        state_d        = TONE;
                    end
                end
                TONE: begin
                    if (cnt_q == '0) begin
                        ton_d    = 1'b0;
                        sonido_d = '0;
                        cnt_d    = CNT_W'(GAP_CYCLES - 1);
                        state_d  = GAP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        if (dbl_q && !second_q) begin
                            second_d = 1'b1;
                            cnt_d    = CNT_W'(SHORT_CYCLES - 1);
                            ton_d    = 1'b1;
                            sonido_d = SND_W'(FREQ_WORD);
                            state_d  = TONE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A grant clears pending, but a request on the same edge re-arms it
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                pend_d[i] = 1'b0;
            end
            if (req[i] && (!pend_q[i] || grant[i])) begin
                pend_d[i] = 1'b1;
                kind_d[i] = kind[2*i +: 2];
            end
        end
    end

    // busy tracks the registered state and pending bits
    assign busy_d    = (state_d != IDLE) | (|pend_d);

    assign ack       = ack_q;
    assign active_id = id_q;
    assign busy      = busy_q;
    assign s_enable  = ton_q;
    assign sonido    = sonido_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Testbench for beep_scheduler: expected beeps are queued when requests are
// driven and popped when the DUT acknowledges a grant; the tone/gap pattern of
// each served beep is then checked cycle by cycle.
module tb_beep_scheduler;

    localparam int unsigned NREQ = 3;
    localparam int unsigned SC   = 4;
    localparam int unsigned LC   = 10;
    localparam int unsigned GC   = 2;
    localparam int unsigned FW   = 32000;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  req;
    logic [5:0]  kind;
    logic [2:0]  ack;
    logic [1:0]  active_id;
    logic        busy;
    logic        s_enable;
    logic [51:0] sonido;

    int checks;
    int failures;

    typedef struct {
        int id;
        int kind;
    } beep_t;

    beep_t exp_q[$];

    beep_scheduler #(
        .NREQ         (NREQ),
        .SHORT_CYCLES (SC),
        .LONG_CYCLES  (LC),
        .GAP_CYCLES   (GC),
        .FREQ_WORD    (FW),
        .CNT_W        (25)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .kind      (kind),
        .ack       (ack),
        .active_id (active_id),
        .busy      (busy),
        .s_enable  (s_enable),
        .sonido    (sonido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beep(input int id, input int k);
        beep_t b;
        b.id   = id;
        b.kind = k;
        exp_q.push_back(b);
    endtask

    // Wait up to max_wait edges for an ack, pop the expected beep and check its
    // full tone/gap pattern. Requests are one-shot: cleared after the first edge.
    task automatic serve_beep(input int max_wait);
        int    waited;
        bit    got;
        beep_t e;
        int    segs[$];
        bit    tone;
        waited = 0;
        got    = 1'b0;
        while (!got && waited < max_wait) begin
            step();
            req = '0;
            waited++;
            if (ack != '0) got = 1'b1;
        end
        if (!got) begin
            check("ack_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("unexpected_ack", 64'(ack), 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check("ack_id", 64'(ack), 64'd1 << e.id);
        if (e.kind == 2)      segs = '{SC, GC, SC, GC};
        else if (e.kind == 1) segs = '{LC, GC};
        else                  segs = '{SC, GC};
        foreach (segs[s]) begin
            tone = (s % 2 == 0);
            for (int k = 0; k < segs[s]; k++) begin
                check(tone ? "tone_en" : "gap_en", 64'(s_enable), 64'(tone));
                check(tone ? "tone_freq" : "gap_freq", 64'(sonido), tone ? 64'(FW) : 64'd0);
                check("active_id", 64'(active_id), 64'(e.id));
                check("busy_in_beep", 64'(busy), 64'd1);
                if (s > 0 || k > 0) check("ack_once", 64'(ack), 64'd0);
                step();
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        enable   = 1'b1;
        req      = '0;
        kind     = '0;

        // Reset held: inputs toggle, outputs stay zero
        #1;
        repeat (3) begin
            req  = 3'($urandom);
            kind = 6'($urandom);
            step();
            check("rst_ack", 64'(ack), 64'd0);
            check("rst_sen", 64'(s_enable), 64'd0);
            check("rst_sonido", 64'(sonido), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_id", 64'(active_id), 64'd0);
        end
        req   = '0;
        kind  = '0;
        reset = 1'b1;
        repeat (3) begin
            step();
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_ack", 64'(ack), 64'd0);
        end

        // Single short beep from requester 1, exact latency
        req  = 3'b010;
        kind = 6'b00_00_00;
        push_beep(1, 0);
        step();
        req = '0;
        check("pend_busy", 64'(busy), 64'd1);
        check("pend_no_ack", 64'(ack), 64'd0);
        serve_beep(1);
        check("short_done_busy", 64'(busy), 64'd0);
        check("short_done_sen", 64'(s_enable), 64'd0);

        // Double-short beep from requester 0
        req  = 3'b001;
        kind = 6'b00_00_10;
        push_beep(0, 2);
        step();
        req = '0;
        serve_beep(1);
        check("dbl_done_busy", 64'(busy), 64'd0);

        // Kind 11 plays as short
        req  = 3'b010;
        kind = 6'b00_11_00;
        push_beep(1, 3);
        step();
        req = '0;
        serve_beep(1);
        check("k11_done_busy", 64'(busy), 64'd0);

        // Simultaneous long(0) and short(2); re-request of 2 as long is ignored
        req  = 3'b101;
        kind = 6'b00_00_01;
        push_beep(0, 1);
        push_beep(2, 0);
        step();
        req  = 3'b100;
        kind = 6'b01_00_00;
        serve_beep(1);
        check("prio_pend_busy", 64'(busy), 64'd1);
        check("prio_idle_ack", 64'(ack), 64'd0);
        serve_beep(1);
        check("prio_done_busy", 64'(busy), 64'd0);

        // Freeze mid-tone; a request latches during the freeze
        req  = 3'b001;
        kind = 6'b00_00_00;
        step();
        req = '0;
        step();
        check("frz_ack", 64'(ack), 64'd1);
        check("frz_sen_c1", 64'(s_enable), 64'd1);
        step();
        check("frz_sen_c2", 64'(s_enable), 64'd1);
        enable = 1'b0;
        req    = 3'b010;
        kind   = 6'b00_01_00;
        repeat (5) begin
            step();
            req = '0;
            check("frz_hold_sen", 64'(s_enable), 64'd1);
            check("frz_hold_freq", 64'(sonido), 64'(FW));
            check("frz_hold_ack", 64'(ack), 64'd0);
        end
        enable = 1'b1;
        repeat (2) begin
            step();
            check("frz_resume_sen", 64'(s_enable), 64'd1);
        end
        step();
        check("frz_gap1_sen", 64'(s_enable), 64'd0);
        check("frz_gap1_freq", 64'(sonido), 64'd0);
        step();
        check("frz_gap2_sen", 64'(s_enable), 64'd0);
        step();
        // Idle with requester 1 pending: grant deferred while enable is low
        enable = 1'b0;
        repeat (3) begin
            step();
            check("defer_ack", 64'(ack), 64'd0);
            check("defer_sen", 64'(s_enable), 64'd0);
            check("defer_busy", 64'(busy), 64'd1);
        end
        enable = 1'b1;
        push_beep(1, 1);
        serve_beep(1);
        check("defer_done_busy", 64'(busy), 64'd0);

        // Reset pulsed mid long tone with requester 1 pending
        req  = 3'b011;
        kind = 6'b00_00_01;
        step();
        req = '0;
        step();
        check("mid_ack", 64'(ack), 64'd1);
        repeat (3) step();
        check("mid_sen", 64'(s_enable), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_sen", 64'(s_enable), 64'd0);
        check("async_freq", 64'(sonido), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_id", 64'(active_id), 64'd0);
        step();
        reset = 1'b1;
        repeat (4) begin
            step();
            check("post_rst_ack", 64'(ack), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
            check("post_rst_sen", 64'(s_enable), 64'd0);
        end
        exp_q.delete();
        req  = 3'b100;
        kind = 6'b00_00_00;
        push_beep(2, 0);
        step();
        req = '0;
        serve_beep(1);
        check("final_busy", 64'(busy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beep_scheduler.md
Name: beep_scheduler

Overview:
Arbitrates beep requests from several front-panel sources (key click, alarm, error) and sequences the shared tone generator. Each request is latched, granted by fixed priority, and played as a short, long or double-short beep. Every beep is followed by a mandatory silent gap. Outputs drive the tone generator's enable and frequency word directly.

Parameters:
NREQ, 3, number of requesters; index 0 has the highest priority.
SHORT_CYCLES, 5000000, short tone length in enabled clock cycles.
LONG_CYCLES, 25000000, long tone length in enabled clock cycles.
GAP_CYCLES, 2500000, silent gap after each tone, and between the two pulses of a double beep.
FREQ_WORD, 32000, frequency word driven while a tone plays.
CNT_W, 25, counter width; must hold the largest cycle parameter minus 1.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
enable  in  1  advance enable; when low, the FSM and counters freeze.
req  in  NREQ  per-requester request strobe, sampled every clock.
kind  in  2*NREQ  beep type for requester i in bits [2i+1:2i]: 00 short, 01 long, 10 double-short, 11 treated as short.
ack  out  NREQ  one-cycle grant pulse per requester.
active_id  out  2  index of the requester being served; valid while busy and not idle.
busy  out  1  high when the FSM is not IDLE or any request is pending.
s_enable  out  1  tone generator enable.
sonido  out  52  frequency word; FREQ_WORD while s_enable is high, else 0.

Behaviour:
- Reset (async, reset=0): pending, stored kinds, ack, s_enable, sonido, active_id, counters all 0; busy 0; state IDLE. Reset takes effect immediately, including mid-tone.
- Pending latch:
  - req[i]=1 at an edge sets pending[i] and captures kind[i]. This is independent of enable.
  - req[i] while pending[i] is already set is ignored; the stored kind is not overwritten.
  - If req[i] arrives on the same edge that grants i, the set wins and i is pending again.
- States: IDLE, TONE, GAP.
- IDLE (enable=1) with any pending bit set:
  - Grant the lowest pending index i.
  - Pulse ack[i] for one cycle and clear pending[i].
  - active_id <= i.
  - Load counter with SHORT_CYCLES-1 or LONG_CYCLES-1 per the stored kind; second_pulse <= 0.
  - s_enable <= 1, sonido <= FREQ_WORD; go to TONE.
- Latency: req captured at edge n → grant, ack and s_enable high after edge n+1.
- TONE: counter decrements each enabled cycle. At counter 0: s_enable <= 0, sonido <= 0, load GAP_CYCLES-1, go to GAP.
  - Result: s_enable is high for exactly SHORT_CYCLES or LONG_CYCLES enabled cycles.
- GAP: counter decrements each enabled cycle. At counter 0:
  - If kind is double and second_pulse=0: set second_pulse <= 1, load SHORT_CYCLES-1, s_enable <= 1, sonido <= FREQ_WORD, go to TONE.
  - Otherwise go to IDLE. A new grant can occur on the following edge.
- No preemption: a higher-priority request waits until the current beep, including its final gap, completes.
- enable=0: state, counters and outputs hold; ack is forced 0; requests still latch. The grant is deferred until enable returns high.
- Simultaneous requests are resolved only by priority. A lower index re-requesting continuously can starve higher indices; this is accepted.
- busy = (state != IDLE) | (|pending).

Test Plan (SHORT_CYCLES=4, LONG_CYCLES=10, GAP_CYCLES=2, FREQ_WORD=32000, enable=1 unless stated):
1. Hold reset low, toggle req and kind → all outputs 0; after release, busy stays 0 with no req.
2. req[1]=1 for one cycle, kind short at edge 0 → ack[1] high after edge 1 for 1 cycle; s_enable high and sonido=32000 after edges 1–4; both 0 after edge 5; IDLE and busy=0 after edge 7.
3. req[0] double-short → s_enable pattern high 4, low 2, high 4, low 2; a single ack[0] pulse; active_id=0 throughout.
4. req[0] long and req[2] short on the same edge → ack[0] first, 10 tone cycles plus 2 gap cycles; ack[2] on the edge after the gap ends; req[2] re-asserted while pending with kind long still plays a short beep.
5. Short beep started, enable=0 for 5 cycles after the 2nd tone cycle → s_enable and sonido held during the freeze; 4 enabled tone cycles in total.
6. Long beep playing with req[1] pending, reset pulsed low mid-tone → s_enable and sonido drop to 0 asynchronously; after release, no ack is issued and busy=0 until a new req arrives.
